// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
//   Moves a one-pixel-per-step ball around a 640x480 play field for a
//   breakout-style game. The ball sits on the slider while serving, bounces
//   off whatever the collision logic reports while running, and costs a life
//   when it falls below the floor. After the last life the game freezes until
//   reset.
//
// Parameters
//   CLK_DIV     : move-tick period in clk cycles at level 0
//   START_LIVES : lives loaded at reset
//   DEAD_TICKS  : move ticks spent in DEAD before leaving it
//
// Ports
//   clk        in   1   system clock, everything changes on the rising edge
//   rst        in   1   synchronous, active-high reset
//   iLevel     in   2   game level: 0 slow, 1 twice as fast, 2/3 four times
//   iStart     in   1   launch request, only honoured while serving
//   iSlider_x  in  10   slider centre x (pixels)
//   iSlider_y  in  10   slider centre y (pixels)
//   iCrash     in   4   collision flags {left, right, up, down}, bit 3 = left
//   iBallDie   in   1   ball has dropped below the play floor
//   oBall_x    out 10   ball centre x (pixels)
//   oBall_y    out 10   ball centre y (pixels)
//   oState     out  2   0 SERVE, 1 RUN, 2 DEAD, 3 OVER (also the FSM debug view)
//   oLives     out  2   lives remaining
//   oMove      out  1   high for the one clk in which a new RUN position shows
//
// Coordinates: x grows to the right, y grows downward. dx/dy = 1 means the
// coordinate is increasing.
// -----------------------------------------------------------------------------
module ball_motion #(
    parameter int CLK_DIV     = 250000,
    parameter int START_LIVES = 3,
    parameter int DEAD_TICKS  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] iLevel,
    input  logic       iStart,
    input  logic [9:0] iSlider_x,
    input  logic [9:0] iSlider_y,
    input  logic [3:0] iCrash,
    input  logic       iBallDie,
    output logic [9:0] oBall_x,
    output logic [9:0] oBall_y,
    output logic [1:0] oState,
    output logic [1:0] oLives,
    output logic       oMove
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [31:0] DIV_BASE  = 32'(CLK_DIV);
    localparam logic [31:0] DEAD_LAST = (DEAD_TICKS > 0) ? 32'(DEAD_TICKS - 1) : 32'd0;
    localparam logic [9:0]  X_MIN     = 10'd10;
    localparam logic [9:0]  X_MAX     = 10'd630;
    localparam logic [9:0]  Y_MIN     = 10'd10;
    localparam logic [9:0]  Y_MAX     = 10'd470;
    localparam logic [9:0]  RST_X     = 10'd320;
    localparam logic [9:0]  RST_Y     = 10'd400;
    localparam logic [9:0]  SERVE_GAP = 10'd31;   // ball rests this far above slider centre

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t      state,    state_n;
    logic [9:0]  ball_x,   ball_x_n;
    logic [9:0]  ball_y,   ball_y_n;
    logic        dx,       dx_n;
    logic        dy,       dy_n;
    logic [1:0]  lives,    lives_n;
    logic        move,     move_n;
    logic [31:0] dead_cnt, dead_cnt_n;
    logic [31:0] tick_cnt;

    logic [31:0] period;
    logic        tick;

    // -------------------------------------------------------------------------
    // Move-tick generator. Runs in every state. The compare is ">=" rather
    // than "==" so that switching to a faster level while the counter is
    // already past the new terminal count produces a tick on the next clk
    // instead of letting the counter run away.
    // -------------------------------------------------------------------------
    always_comb begin
        period = DIV_BASE;
        case (iLevel)
            2'd0:    period = DIV_BASE;
            2'd1:    period = DIV_BASE >> 1;
            default: period = DIV_BASE >> 2;
        endcase
        // A tiny divider would otherwise give period 0 and a wrapped compare.
        if (period == 32'd0) begin
            period = 32'd1;
        end
    end

    assign tick = (tick_cnt >= (period - 32'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 32'd0;
        end else if (tick) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // One-pixel step with clamping to [lo, hi]. Also pulls a position that
    // started outside the field (e.g. a slider reported off-screen) back in.
    // -------------------------------------------------------------------------
    function automatic logic [9:0] step_clamp(input logic [9:0] pos,
                                              input logic       up,
                                              input logic [9:0] lo,
                                              input logic [9:0] hi);
        logic [9:0] nxt;
        if (up) begin
            nxt = (pos >= hi) ? hi : pos + 10'd1;
        end else begin
            nxt = (pos <= lo) ? lo : pos - 10'd1;
        end
        if (nxt < lo) begin
            nxt = lo;
        end
        if (nxt > hi) begin
            nxt = hi;
        end
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SERVE;
            ball_x   <= RST_X;
            ball_y   <= RST_Y;
            dx       <= 1'b1;
            dy       <= 1'b0;
            lives    <= 2'(START_LIVES);
            move     <= 1'b0;
            dead_cnt <= 32'd0;
        end else begin
            state    <= state_n;
            ball_x   <= ball_x_n;
            ball_y   <= ball_y_n;
            dx       <= dx_n;
            dy       <= dy_n;
            lives    <= lives_n;
            move     <= move_n;
            dead_cnt <= dead_cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        logic dx_f;
        logic dy_f;

        state_n    = state;
        ball_x_n   = ball_x;
        ball_y_n   = ball_y;
        dx_n       = dx;
        dy_n       = dy;
        lives_n    = lives;
        move_n     = 1'b0;
        dead_cnt_n = dead_cnt;
        dx_f       = dx;
        dy_f       = dy;

        case (state)
            SERVE: begin
                // Ball rides on the slider and is always launched up-right.
                ball_x_n   = iSlider_x;
                ball_y_n   = iSlider_y - SERVE_GAP;
                dx_n       = 1'b1;
                dy_n       = 1'b0;
                dead_cnt_n = 32'd0;
                if (iStart) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (iBallDie) begin
                    // Losing the ball beats any step that would land this clk.
                    state_n    = DEAD;
                    dead_cnt_n = 32'd0;
                    lives_n    = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                end else if (tick) begin
                    // A flag only flips a direction that still heads into the
                    // obstacle, so a flag held across ticks cannot flip back.
                    if (!dx && iCrash[3]) begin
                        dx_f = 1'b1;
                    end else if (dx && iCrash[2]) begin
                        dx_f = 1'b0;
                    end
                    if (!dy && iCrash[1]) begin
                        dy_f = 1'b1;
                    end else if (dy && iCrash[0]) begin
                        dy_f = 1'b0;
                    end
                    // Step in the updated direction so the ball leaves the
                    // obstacle on the same tick it bounced.
                    dx_n     = dx_f;
                    dy_n     = dy_f;
                    ball_x_n = step_clamp(ball_x, dx_f, X_MIN, X_MAX);
                    ball_y_n = step_clamp(ball_y, dy_f, Y_MIN, Y_MAX);
                    move_n   = 1'b1;
                end
            end

            DEAD: begin
                if (tick) begin
                    if (dead_cnt >= DEAD_LAST) begin
                        dead_cnt_n = 32'd0;
                        state_n    = (lives != 2'd0) ? SERVE : OVER;
                    end else begin
                        dead_cnt_n = dead_cnt + 32'd1;
                    end
                end
            end

            OVER: begin
                // Frozen until reset.
            end

            default: begin
                state_n = SERVE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign oBall_x = ball_x;
    assign oBall_y = ball_y;
    assign oState  = state;
    assign oLives  = lives;
    assign oMove   = move;

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250000, base move-tick period in clk cycles at level 0.
REQ-002 SHALL have parameter START_LIVES, default 3, lives loaded at reset.
REQ-003 SHALL have parameter DEAD_TICKS, default 64, move ticks spent in DEAD before leaving.
REQ-004 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port iLevel, input, 2, game level selecting speed.
REQ-007 SHALL have port iStart, input, 1, launch request, sampled every clk.
REQ-008 SHALL have port iSlider_x, input, 10, slider centre x in pixels.
REQ-009 SHALL have port iSlider_y, input, 10, slider centre y in pixels.
REQ-010 SHALL have port iCrash, input, 4, collision flags {left, right, up, down}, bit 3 = left.
REQ-011 SHALL have port iBallDie, input, 1, ball below play floor.
REQ-012 SHALL have port oBall_x, output, 10, ball centre x in pixels.
REQ-013 SHALL have port oBall_y, output, 10, ball centre y in pixels.
REQ-014 SHALL have port oState, output, 2, 0 SERVE, 1 RUN, 2 DEAD, 3 OVER.
REQ-015 SHALL have port oLives, output, 2, lives remaining.
REQ-016 SHALL have port oMove, output, 1, one-clk strobe per position step.

Function
REQ-017 Tick counter SHALL run in every state; period P = CLK_DIV for iLevel 0, CLK_DIV/2 for 1, CLK_DIV/4 for 2 and 3.
REQ-018 Tick SHALL assert for one clk when counter >= P-1; counter then returns to 0; a level change takes effect without a counter hang.
REQ-019 Direction regs dx, dy SHALL use 1 = increasing coordinate; y increases downward.
REQ-020 SERVE: every clk, oBall_x = iSlider_x, oBall_y = iSlider_y - 31; dx=1, dy=0.
REQ-021 SERVE with iStart=1 SHALL enter RUN next clk; iStart SHALL be ignored in every other state.
REQ-022 RUN on tick: left flag sets dx=1 only if dx=0; right flag clears dx only if dx=1; up sets dy=1 only if dy=0; down clears dy only if dy=1.
REQ-023 RUN on the same tick SHALL step x and y by one pixel each in the updated directions, so the step after a flip moves away from the obstacle.
REQ-024 Stepped position SHALL clamp x to 10..630 and y to 10..470.
REQ-025 oMove SHALL be 1 for exactly the clk in which a RUN step is applied, otherwise 0.
REQ-026 iCrash SHALL be ignored outside RUN and between ticks.
REQ-027 RUN with iBallDie=1 SHALL enter DEAD next clk, decrement oLives saturating at 0, and not apply any step that clk.
REQ-028 If iBallDie and a tick coincide, death SHALL win.
REQ-029 DEAD: position SHALL hold; dead counter SHALL count ticks; at DEAD_TICKS, go to SERVE if oLives>0, else OVER.
REQ-030 OVER: position, lives and state SHALL hold until rst.

Reset
REQ-031 rst=1 SHALL load: oState=SERVE, oLives=START_LIVES, oBall_x=320, oBall_y=400, oMove=0, dx=1, dy=0, tick and dead counters 0.
REQ-032 rst SHALL take priority over every event in the same clk, including mid-RUN and mid-DEAD.
REQ-033 First clk after rst release SHALL apply SERVE tracking per REQ-020.

Verification
REQ-034 Set CLK_DIV=8, iLevel=0, slider (320,450), iStart pulse. Response: SERVE ball (320,419) -> RUN. One tick later: (321,418), oMove pulse.
REQ-035 In RUN, dx=1, hold iCrash=4'b0100 across two ticks. Response: dx clears on the first tick and x decrements on both ticks; no second flip.
REQ-036 Ball at x=629, dx=1, iCrash=0. Response: next tick x=630 (clamp); later ticks stay 630 until a right flag flips dx.
REQ-037 iBallDie=1 coinciding with a tick. Response: no step; oState=DEAD; oLives 3->2. After 64 ticks: SERVE.
REQ-038 Three deaths from reset. Response: oLives reaches 0, then OVER; iStart ignored; rst restores oLives=3 and SERVE.
REQ-039 iLevel=2 with CLK_DIV=8. Response: ticks every 2 clk. Switching to iLevel=0 mid-count still gives the next tick within 8 clk.
